jc_step_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit Johnson phase ring. The block owns the ring register and advances it a commanded number of steps, forward or reverse, with a programmable dwell between steps. It also supports pause, abort and completion signalling. It sits between a host or control FSM and any logic that consumes the 8 Johnson phases, such as phase-stepped drivers or time-slot enables.

---
 rtl/jc_step_if.sv | 28 ++
 rtl/jc_step_ctrl.sv | 129 ++++++++++++
 tb/tb_jc_step_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jc_step_if.sv
// Command handshake bundle for jc_step_ctrl: the host drives a step request,
// the sequencer answers with cmd_ready while it is idle.
interface jc_step_if #(
    parameter int CNT_W = 8,
    parameter int DWL_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DWL_W-1:0] cmd_dwell;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  cmd_dwell,
        output cmd_ready
    );
endinterface

// File: rtl/jc_step_ctrl.sv
// Command-driven sequencer for a 4-bit Johnson phase ring: advances the ring
// a commanded number of steps in either direction with a dwell between steps.
module jc_step_ctrl #(
    parameter int CNT_W = 8,
    parameter int DWL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jc_step_if.slave         cmd,
    input  logic             pause,
    input  logic             abort,
    output logic [3:0]       Q,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [3:0]       q_r;
    logic [CNT_W-1:0] rem_r;
    logic [DWL_W-1:0] dwell_cnt_r;
    logic [DWL_W-1:0] dwell_r;
    logic             dir_r;
    logic             done_r;

    function automatic logic [3:0] ring_next(input logic [3:0] q, input logic rev);
        ring_next = rev ? {q[2:0], ~q[3]} : {~q[0], q[3:1]};
    endfunction

    // Position of a legal Johnson code in the forward sequence.
    function automatic logic [2:0] ring_phase(input logic [3:0] q);
        case (q)
            4'b0000: ring_phase = 3'd0;
            4'b1000: ring_phase = 3'd1;
            4'b1100: ring_phase = 3'd2;
            4'b1110: ring_phase = 3'd3;
            4'b1111: ring_phase = 3'd4;
            4'b0111: ring_phase = 3'd5;
            4'b0011: ring_phase = 3'd6;
            4'b0001: ring_phase = 3'd7;
            default: ring_phase = 3'd0;
        endcase
    endfunction

    // Sequencer FSM: command accept, dwell countdown, ring advance, pause/abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_r         <= 4'b0000;
            rem_r       <= {CNT_W{1'b0}};
            dwell_cnt_r <= {DWL_W{1'b0}};
            dwell_r     <= {DWL_W{1'b0}};
            dir_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        dir_r       <= cmd.cmd_dir;
                        dwell_r     <= cmd.cmd_dwell;
                        rem_r       <= cmd.cmd_steps;
                        dwell_cnt_r <= cmd.cmd_dwell;
                        if (cmd.cmd_steps == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (pause) begin
                        state_r <= ST_PAUSE;
                    end else if (dwell_cnt_r != {DWL_W{1'b0}}) begin
                        dwell_cnt_r <= dwell_cnt_r - {{(DWL_W-1){1'b0}}, 1'b1};
                    end else begin
                        q_r         <= ring_next(q_r, dir_r);
                        dwell_cnt_r <= dwell_r;
                        // RUN is only ever entered with a non-zero count, so
                        // the floor at zero is purely defensive.
                        if (rem_r != {CNT_W{1'b0}}) begin
                            rem_r <= rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            rem_r <= {CNT_W{1'b0}};
                        end
                        if (rem_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (!pause) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q             = q_r;
    assign phase         = ring_phase(q_r);
    assign remaining     = rem_r;
    assign done          = done_r;
    assign busy          = (state_r == ST_RUN) || (state_r == ST_PAUSE);
    assign cmd.cmd_ready = (state_r == ST_IDLE);
endmodule

// File: tb/tb_jc_step_ctrl.sv
// Directed self-checking bench for jc_step_ctrl with hand-computed ring states.
module tb_jc_step_ctrl;
    logic       clk;
    logic       rst;
    logic       pause;
    logic       abort;
    logic [3:0] Q;
    logic [2:0] phase;
    logic [7:0] remaining;
    logic       busy;
    logic       done;
    int         n_cmp;
    int         n_err;
    int         acc;

    jc_step_if #(.CNT_W(8), .DWL_W(8)) cif ();

    jc_step_ctrl #(.CNT_W(8), .DWL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .pause     (pause),
        .abort     (abort),
        .Q         (Q),
        .phase     (phase),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] steps, input logic dir, input logic [7:0] dwell);
        cif.cmd_valid = 1'b1;
        cif.cmd_steps = steps;
        cif.cmd_dir   = dir;
        cif.cmd_dwell = dwell;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    logic [3:0] rev_exp [9];
    logic [3:0] pq;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rev_exp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
        rst = 1'b1; pause = 1'b0; abort = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_steps = 8'd0; cif.cmd_dir = 1'b0; cif.cmd_dwell = 8'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_q", Q, 4'h0);
        chk("rst_phase", phase, 3'd0);
        chk("rst_rem", remaining, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", cif.cmd_ready, 1'b1);

        // Forward, dwell 1, two steps
        issue(8'd2, 1'b0, 8'd1);
        chk("fwd_e0_busy", busy, 1'b1);
        chk("fwd_e0_rem", remaining, 8'd2);
        tick(); chk("fwd_e1_q", Q, 4'h0);
        tick(); chk("fwd_e2_q", Q, 4'h8); chk("fwd_e2_rem", remaining, 8'd1); chk("fwd_e2_phase", phase, 3'd1);
        tick(); chk("fwd_e3_q", Q, 4'h8); chk("fwd_e3_done", done, 1'b0);
        tick(); chk("fwd_e4_q", Q, 4'hC); chk("fwd_e4_done", done, 1'b1);
        chk("fwd_e4_ready", cif.cmd_ready, 1'b0); chk("fwd_e4_rem", remaining, 8'd0);
        tick(); chk("fwd_e5_done", done, 1'b0); chk("fwd_e5_ready", cif.cmd_ready, 1'b1);
        chk("fwd_e5_busy", busy, 1'b0); chk("fwd_e5_q", Q, 4'hC);

        // Reset asserted mid-run
        issue(8'd5, 1'b0, 8'd0);
        tick(); chk("mid_q", Q, 4'hE);
        rst = 1'b1;
        tick(); chk("mid_rst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        chk("mid_rst_q", Q, 4'h0); chk("mid_rst_rem", remaining, 8'd0);
        chk("mid_rst_busy", busy, 1'b0); chk("mid_rst_done2", done, 1'b0);
        chk("mid_rst_ready", cif.cmd_ready, 1'b1);

        // Reverse with wrap, nine steps
        issue(8'd9, 1'b1, 8'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rev_q%0d", i), Q, rev_exp[i]);
            chk($sformatf("rev_done%0d", i), done, (i == 8) ? 1'b1 : 1'b0);
        end
        chk("rev_phase", phase, 3'd7);
        chk("rev_rem", remaining, 8'd0);
        tick(); chk("rev_after_done", done, 1'b0); chk("rev_after_ready", cif.cmd_ready, 1'b1);

        // Pause for 5 cycles after the first advance (Q starts at 0001)
        issue(8'd4, 1'b0, 8'd2);
        tick(); tick(); tick();
        chk("pau_adv1_q", Q, 4'h0); chk("pau_adv1_rem", remaining, 8'd3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("pau_hold_q%0d", i), Q, 4'h0);
            chk($sformatf("pau_hold_rem%0d", i), remaining, 8'd3);
            chk($sformatf("pau_hold_busy%0d", i), busy, 1'b1);
        end
        pause = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            pq = (k <= 3) ? 4'h0 : (k <= 6) ? 4'h8 : (k <= 9) ? 4'hC : 4'hE;
            chk($sformatf("pau_run_q%0d", k), Q, pq);
            chk($sformatf("pau_run_done%0d", k), done, (k == 10) ? 1'b1 : 1'b0);
        end
        chk("pau_end_rem", remaining, 8'd0);
        tick(); chk("pau_after_done", done, 1'b0);

        // Abort with pause after 3 of 6 forward steps from 0000
        rst = 1'b1; tick(); rst = 1'b0;
        issue(8'd6, 1'b0, 8'd0);
        tick(); tick(); tick();
        chk("abt_pre_q", Q, 4'hE); chk("abt_pre_rem", remaining, 8'd3);
        pause = 1'b1; abort = 1'b1;
        tick();
        pause = 1'b0; abort = 1'b0;
        chk("abt_busy", busy, 1'b0); chk("abt_q", Q, 4'hE);
        chk("abt_rem", remaining, 8'd3); chk("abt_done", done, 1'b0);
        chk("abt_ready", cif.cmd_ready, 1'b1);
        issue(8'd1, 1'b1, 8'd0);
        chk("abt_next_accept", busy, 1'b1);
        tick(); chk("abt_next_q", Q, 4'hC); chk("abt_next_done", done, 1'b1);
        tick(); chk("abt_next_idle", cif.cmd_ready, 1'b1);

        // Zero steps with valid held: accepts two cycles apart
        cif.cmd_valid = 1'b1; cif.cmd_steps = 8'd0; cif.cmd_dir = 1'b0; cif.cmd_dwell = 8'd3;
        tick();
        chk("zero_done", done, 1'b1); chk("zero_q", Q, 4'hC);
        chk("zero_ready", cif.cmd_ready, 1'b0); chk("zero_busy", busy, 1'b0);
        tick(); chk("zero_idle_done", done, 1'b0); chk("zero_idle_ready", cif.cmd_ready, 1'b1);
        tick(); chk("zero_reaccept_done", done, 1'b1);
        cif.cmd_valid = 1'b0;
        tick(); chk("zero_end_done", done, 1'b0); chk("zero_end_ready", cif.cmd_ready, 1'b1);

        // Busy handshake: valid held across a two-step run
        acc = 0;
        cif.cmd_valid = 1'b1; cif.cmd_steps = 8'd2; cif.cmd_dir = 1'b0; cif.cmd_dwell = 8'd0;
        for (int k = 0; k < 5; k++) begin
            if (cif.cmd_valid && cif.cmd_ready) acc++;
            if (k >= 1 && k <= 3) chk($sformatf("hs_ready%0d", k), cif.cmd_ready, 1'b0);
            tick();
        end
        cif.cmd_valid = 1'b0;
        chk("hs_accepts", acc, 2);
        tick(); chk("hs_q5", Q, 4'h7);
        tick(); chk("hs_q6", Q, 4'h3); chk("hs_done6", done, 1'b1);
        tick(); chk("hs_idle", cif.cmd_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
